// File: rtl/fetch_flush_ctrl.sv
// I-fetch sequencer: counts accepted-but-unreturned I-Cache requests, throttles at MAX_OUT,
// merges the three redirect sources and drops returns belonging to requests issued before a redirect.
module fetch_flush_ctrl #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_req_i,
  input  logic             inst_index_ok_i,
  input  logic             inst_data_ok_i,
  input  logic             CP0_excOccur_w_i,
  input  logic [31:0]      CP0_excDestPC_w_i,
  input  logic             SBA_flush_w_i,
  input  logic [31:0]      BSC_correctDest_w_i,
  input  logic             BSC_isDiffRes_w_i,
  input  logic [31:0]      BSC_diffDest_w_i,
  output logic             FFC_redirect_o,
  output logic [31:0]      FFC_redirectPC_o,
  output logic             FFC_blockReq_o,
  output logic             FFC_dataValid_o,
  output logic [CNT_W-1:0] FFC_inflight_o,
  output logic             FFC_draining_o,
  output logic             FFC_protoErr_o
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] inflight, inflight_n;
  logic [CNT_W-1:0] kill, kill_n;
  logic             proto_err;
  logic             acc, ret, redirect, err_set;

  assign FFC_blockReq_o = (inflight == MAX_CNT);
  assign acc            = inst_req_i & inst_index_ok_i & ~FFC_blockReq_o;
  assign ret            = inst_data_ok_i;
  assign redirect       = CP0_excOccur_w_i | SBA_flush_w_i | BSC_isDiffRes_w_i;

  always_comb begin
    FFC_redirectPC_o = 32'h0;
    if (CP0_excOccur_w_i)
      FFC_redirectPC_o = CP0_excDestPC_w_i;
    else if (SBA_flush_w_i)
      FFC_redirectPC_o = BSC_correctDest_w_i;
    else if (BSC_isDiffRes_w_i)
      FFC_redirectPC_o = BSC_diffDest_w_i;
  end

  // A return with nothing outstanding (and no same-cycle accept) saturates at zero.
  always_comb begin
    inflight_n = inflight;
    if (acc && !ret)
      inflight_n = inflight + ONE;
    else if (!acc && ret && inflight != '0)
      inflight_n = inflight - ONE;
  end

  // Everything outstanding after this cycle's accept/return is stale on a redirect.
  always_comb begin
    kill_n = kill;
    if (redirect)
      kill_n = inflight_n;
    else if (ret && kill != '0)
      kill_n = kill - ONE;
  end

  assign err_set = (ret && inflight == '0 && !acc) || (inst_index_ok_i && FFC_blockReq_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      inflight  <= '0;
      kill      <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      inflight  <= inflight_n;
      kill      <= kill_n;
      proto_err <= proto_err | err_set;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (redirect && inflight_n != '0)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (redirect)
          state_n = (inflight_n != '0) ? DRAIN : RUN;
        else if (ret && kill == ONE)
          state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    FFC_draining_o = (state == DRAIN);
  end

  assign FFC_redirect_o  = redirect;
  assign FFC_dataValid_o = ret & (kill == '0) & ~redirect;
  assign FFC_inflight_o  = inflight;
  assign FFC_protoErr_o  = proto_err;

endmodule

// File: tb/tb_fetch_flush_ctrl.sv
// Bench for fetch_flush_ctrl: directed scenarios plus constrained-random traffic,
// checked every cycle against a queue of outstanding requests tagged live/stale.
module tb_fetch_flush_ctrl;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             inst_req_i, inst_index_ok_i, inst_data_ok_i;
  logic             CP0_excOccur_w_i, SBA_flush_w_i, BSC_isDiffRes_w_i;
  logic [31:0]      CP0_excDestPC_w_i, BSC_correctDest_w_i, BSC_diffDest_w_i;
  logic             FFC_redirect_o, FFC_blockReq_o, FFC_dataValid_o;
  logic             FFC_draining_o, FFC_protoErr_o;
  logic [31:0]      FFC_redirectPC_o;
  logic [CNT_W-1:0] FFC_inflight_o;

  fetch_flush_ctrl #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_req_i          (inst_req_i),
    .inst_index_ok_i     (inst_index_ok_i),
    .inst_data_ok_i      (inst_data_ok_i),
    .CP0_excOccur_w_i    (CP0_excOccur_w_i),
    .CP0_excDestPC_w_i   (CP0_excDestPC_w_i),
    .SBA_flush_w_i       (SBA_flush_w_i),
    .BSC_correctDest_w_i (BSC_correctDest_w_i),
    .BSC_isDiffRes_w_i   (BSC_isDiffRes_w_i),
    .BSC_diffDest_w_i    (BSC_diffDest_w_i),
    .FFC_redirect_o      (FFC_redirect_o),
    .FFC_redirectPC_o    (FFC_redirectPC_o),
    .FFC_blockReq_o      (FFC_blockReq_o),
    .FFC_dataValid_o     (FFC_dataValid_o),
    .FFC_inflight_o      (FFC_inflight_o),
    .FFC_draining_o      (FFC_draining_o),
    .FFC_protoErr_o      (FFC_protoErr_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: one entry per outstanding request in issue order, 1 = stale.
  bit stale_q[$];
  bit m_perr = 1'b0;
  bit m_acc, m_ret, m_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs and checks every output before the clock edge.
  task automatic drive(input logic req, input logic iok, input logic dok,
                       input logic exc, input logic fl, input logic dif,
                       input logic [31:0] epc = 32'h0, input logic [31:0] cpc = 32'h0,
                       input logic [31:0] dpc = 32'h0);
    logic [31:0] exp_pc;
    bit exp_valid;
    inst_req_i = req; inst_index_ok_i = iok; inst_data_ok_i = dok;
    CP0_excOccur_w_i = exc; SBA_flush_w_i = fl; BSC_isDiffRes_w_i = dif;
    CP0_excDestPC_w_i = epc; BSC_correctDest_w_i = cpc; BSC_diffDest_w_i = dpc;
    #3;
    m_acc   = req && iok && (stale_q.size() != MAX_OUT);
    m_ret   = dok;
    m_redir = exc || fl || dif;
    exp_pc  = exc ? epc : fl ? cpc : dif ? dpc : 32'h0;
    exp_valid = 1'b0;
    if (m_ret) begin
      if (stale_q.size() != 0) exp_valid = !stale_q[0] && !m_redir;
      else                     exp_valid = !m_redir;
    end
    chk("redirect",  {31'b0, FFC_redirect_o},  {31'b0, m_redir});
    chk("redirectPC", FFC_redirectPC_o,        exp_pc);
    chk("dataValid", {31'b0, FFC_dataValid_o}, {31'b0, exp_valid});
    chk("blockReq",  {31'b0, FFC_blockReq_o},  {31'b0, stale_q.size() == MAX_OUT});
    chk("inflight",  32'(FFC_inflight_o),      32'(stale_q.size()));
    chk("draining",  {31'b0, FFC_draining_o},  {31'b0, stale_q.size() != 0 && stale_q[0]});
    chk("protoErr",  {31'b0, FFC_protoErr_o},  {31'b0, m_perr});
  endtask

  // Advances the reference model, then clocks the DUT.
  task automatic fin();
    bit was_empty, was_full, tmp;
    was_empty = (stale_q.size() == 0);
    was_full  = (stale_q.size() == MAX_OUT);
    if (rst) begin
      stale_q.delete();
      m_perr = 1'b0;
    end else begin
      if ((m_ret && was_empty && !m_acc) || (inst_index_ok_i && was_full)) m_perr = 1'b1;
      if (m_acc) stale_q.push_back(1'b0);
      if (m_ret && stale_q.size() != 0) tmp = stale_q.pop_front();
      if (m_redir) foreach (stale_q[i]) stale_q[i] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic req, input logic iok, input logic dok);
    drive(req, iok, dok, 1'b0, 1'b0, 1'b0);
    fin();
  endtask

  initial begin
    rst = 1'b1;
    inst_req_i = 0; inst_index_ok_i = 0; inst_data_ok_i = 0;
    CP0_excOccur_w_i = 0; SBA_flush_w_i = 0; BSC_isDiffRes_w_i = 0;
    CP0_excDestPC_w_i = 0; BSC_correctDest_w_i = 0; BSC_diffDest_w_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    chk("rst_inflight", 32'(FFC_inflight_o), 32'd0);
    chk("rst_block",    {31'b0, FFC_blockReq_o}, 32'd0);
    chk("rst_draining", {31'b0, FFC_draining_o}, 32'd0);
    chk("rst_perr",     {31'b0, FFC_protoErr_o}, 32'd0);

    // Basic flow
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    chk("flow_inflight3", 32'(FFC_inflight_o), 32'd3);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      chk("flow_valid", {31'b0, FFC_dataValid_o}, 32'd1);
      fin();
    end
    chk("flow_inflight0", 32'(FFC_inflight_o), 32'd0);

    // Throttle
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    chk("thr_block", {31'b0, FFC_blockReq_o}, 32'd1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("thr_unblock", {31'b0, FFC_blockReq_o}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);

    // Flush drain
    cyc(1, 1, 0); cyc(1, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h0, 32'hBFC00380, 32'h0);
    chk("flush_pc", FFC_redirectPC_o, 32'hBFC00380);
    fin();
    chk("flush_drain", {31'b0, FFC_draining_o}, 32'd1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    chk("flush_run", {31'b0, FFC_draining_o}, 32'd0);
    cyc(1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("flush_live", {31'b0, FFC_dataValid_o}, 32'd1);
    fin();

    // Priority
    drive(0, 0, 0, 1, 1, 1, 32'h80000180, 32'h1000, 32'h2000);
    chk("prio_pc", FFC_redirectPC_o, 32'h80000180);
    fin();

    // acc + ret + redirect together
    cyc(1, 1, 0);
    drive(1, 1, 1, 0, 0, 1, 32'h0, 32'h0, 32'h3000);
    fin();
    chk("same_inflight", 32'(FFC_inflight_o), 32'd1);
    chk("same_drain",    {31'b0, FFC_draining_o}, 32'd1);
    cyc(0, 0, 1);

    // Constrained-random legal traffic
    for (int n = 0; n < 400; n++) begin
      logic req, iok, dok, exc, fl, dif;
      req = 1'($urandom_range(0, 1));
      iok = (stale_q.size() != MAX_OUT) ? 1'($urandom_range(0, 1)) : 1'b0;
      dok = (stale_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      exc = ($urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      dif = ($urandom_range(0, 9) == 0);
      drive(req, iok, dok, exc, fl, dif, $urandom, $urandom, $urandom);
      fin();
    end
    for (int i = 0; i < MAX_OUT && stale_q.size() != 0; i++) cyc(0, 0, 1);

    // Protocol error and reset
    cyc(0, 0, 1);
    chk("perr_set", {31'b0, FFC_protoErr_o}, 32'd1);
    cyc(0, 0, 0);
    chk("perr_sticky", {31'b0, FFC_protoErr_o}, 32'd1);
    cyc(1, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("rst2_perr",     {31'b0, FFC_protoErr_o}, 32'd0);
    chk("rst2_inflight", 32'(FFC_inflight_o), 32'd0);
    chk("rst2_draining", {31'b0, FFC_draining_o}, 32'd0);
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
